// File: rtl/gamma_sync_ctrl.sv
// -----------------------------------------------------------------------------
// gamma_sync_ctrl
//
// Sequencing controller for the sliding-window CP-correlation datapath that
// produces gamma. One acquisition consumes a continuous complex sample stream,
// hands the datapath r[k] together with r[k-N] (from an internal N-deep history
// buffer), tags each sample through the datapath latency and searches the
// full-window gamma outputs for the largest |Re|+|Im|. The peak index and
// magnitude are reported with a one-cycle strobe when the search completes.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   start                     begin one acquisition (only honoured in IDLE)
//   in_valid / in_ready       sample handshake; in_valid low during ACQ aborts
//   in_real, in_imag          incoming sample, signed Q1.6
//   dp_rst                    clears datapath state (one cycle, in CLR)
//   dp_rk_real/imag           registered r[k] to the datapath
//   dp_rkN_real/imag          registered r[k-N] to the datapath (0 for k < N)
//   gamma_real, gamma_imag    datapath output, signed Q6.8
//   busy                      high in every state except IDLE
//   peak_valid                one-cycle result strobe
//   peak_idx                  search-relative index of the peak
//   peak_mag                  unsigned |Re|+|Im| at the peak
//   sync_err                  one-cycle strobe: stream broke during ACQ
// -----------------------------------------------------------------------------
module gamma_sync_ctrl #(
    parameter int R_W     = 8,
    parameter int GAMMA_W = 15,
    parameter int N       = 64,
    parameter int L       = 16,
    parameter int DP_LAT  = 3,
    parameter int SEARCH  = 80,
    parameter int IDX_W   = 7
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [R_W-1:0]     in_real,
    input  logic signed [R_W-1:0]     in_imag,
    output logic                      dp_rst,
    output logic signed [R_W-1:0]     dp_rk_real,
    output logic signed [R_W-1:0]     dp_rk_imag,
    output logic signed [R_W-1:0]     dp_rkN_real,
    output logic signed [R_W-1:0]     dp_rkN_imag,
    input  logic signed [GAMMA_W-1:0] gamma_real,
    input  logic signed [GAMMA_W-1:0] gamma_imag,
    output logic                      busy,
    output logic                      peak_valid,
    output logic [IDX_W-1:0]          peak_idx,
    output logic [GAMMA_W:0]          peak_mag,
    output logic                      sync_err
);

    // First sample index whose gamma covers a full window, and total samples
    // consumed by one acquisition.
    localparam int FULL  = N + L - 1;
    localparam int TOTAL = FULL + SEARCH;
    localparam int KW    = $clog2(TOTAL + 1);
    localparam int PW    = (N > 1) ? $clog2(N) : 1;
    localparam int TAGS  = DP_LAT + 1;

    localparam logic [KW-1:0]    K_LAST  = KW'(TOTAL - 1);
    localparam logic [KW-1:0]    K_FULL  = KW'(FULL);
    localparam logic [KW-1:0]    K_LAG   = KW'(N);
    localparam logic [PW-1:0]    P_LAST  = PW'(N - 1);
    localparam logic [IDX_W-1:0] IDX_OFF = IDX_W'(FULL);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_ACQ,
        S_DRAIN,
        S_DONE
    } state_t;

    // |v| widened by one bit so that the most negative code maps to
    // 2^(GAMMA_W-1) exactly instead of wrapping.
    function automatic logic [GAMMA_W:0] abs_wide(input logic signed [GAMMA_W-1:0] v);
        logic signed [GAMMA_W:0] w;
        w = {v[GAMMA_W-1], v};
        if (v[GAMMA_W-1]) begin
            return $unsigned(-w);
        end
        return $unsigned(w);
    endfunction

    // |Re|+|Im|; the GAMMA_W+1 result holds the worst case 2^GAMMA_W, so no
    // saturation is needed.
    function automatic logic [GAMMA_W:0] mag_sum(input logic signed [GAMMA_W-1:0] re,
                                                 input logic signed [GAMMA_W-1:0] im);
        return abs_wide(re) + abs_wide(im);
    endfunction

    state_t                  state;
    state_t                  state_nxt;
    logic                    accept;
    logic [KW-1:0]           k;
    logic [PW-1:0]           wptr;
    logic signed [R_W-1:0]   hist_re [N];
    logic signed [R_W-1:0]   hist_im [N];

    logic [TAGS-1:0]         vld_p;
    logic [KW-1:0]           tag_k_p [TAGS];
    logic [KW-1:0]           tag_k_out;
    logic                    drain_done;

    logic [GAMMA_W:0]        gamma_mag;
    logic                    cmp_en;
    logic [GAMMA_W:0]        best_mag;
    logic [IDX_W-1:0]        best_idx;
    logic [GAMMA_W:0]        best_mag_nxt;
    logic [IDX_W-1:0]        best_idx_nxt;

    // The datapath cannot stall, so in ACQ every in_valid cycle is an accept.
    assign accept = (state == S_ACQ) && in_valid;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_CLR;
                end
            end
            S_CLR: begin
                state_nxt = S_ACQ;
            end
            S_ACQ: begin
                if (!in_valid) begin
                    state_nxt = S_IDLE;
                end else if (k == K_LAST) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Only the last tag is left at the pipe output: it is
                // compared this cycle, so the result is final next cycle.
                if (drain_done) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------------
    always_comb begin
        in_ready   = 1'b0;
        dp_rst     = 1'b0;
        busy       = 1'b1;
        peak_valid = 1'b0;
        case (state)
            S_IDLE:  busy       = 1'b0;
            S_CLR:   dp_rst     = 1'b1;
            S_ACQ:   in_ready   = 1'b1;
            S_DONE:  peak_valid = 1'b1;
            default: ;
        endcase
    end

    // Sample counter and history write pointer.
    always_ff @(posedge clk) begin
        if (rst || state == S_CLR) begin
            k    <= '0;
            wptr <= '0;
        end else if (accept) begin
            k    <= k + 1'b1;
            wptr <= (wptr == P_LAST) ? '0 : wptr + 1'b1;
        end
    end

    // History buffer: the slot at wptr still holds r[k-N] when r[k] arrives,
    // so it is read before being overwritten in the same edge.
    always_ff @(posedge clk) begin
        if (accept) begin
            hist_re[wptr] <= in_real;
            hist_im[wptr] <= in_imag;
        end
    end

    // ------------------------------------------------------------------------
    // Stage p0: registered datapath inputs. Zero whenever no sample is taken.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || !accept) begin
            dp_rk_real  <= '0;
            dp_rk_imag  <= '0;
            dp_rkN_real <= '0;
            dp_rkN_imag <= '0;
        end else begin
            dp_rk_real <= in_real;
            dp_rk_imag <= in_imag;
            // Slots not yet written in this acquisition may hold stale data.
            if (k < K_LAG) begin
                dp_rkN_real <= '0;
                dp_rkN_imag <= '0;
            end else begin
                dp_rkN_real <= hist_re[wptr];
                dp_rkN_imag <= hist_im[wptr];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stages p0..pDP_LAT: sample tag travelling alongside the datapath, so the
    // tag at the last stage names the sample whose gamma is on gamma_*.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || state == S_CLR) begin
            vld_p <= '0;
        end else begin
            vld_p <= {vld_p[TAGS-2:0], accept};
        end
    end

    always_ff @(posedge clk) begin
        tag_k_p[0] <= k;
        for (int i = 1; i < TAGS; i++) begin
            tag_k_p[i] <= tag_k_p[i-1];
        end
    end

    assign tag_k_out  = tag_k_p[TAGS-1];
    assign drain_done = ~|vld_p[TAGS-2:0];

    // ------------------------------------------------------------------------
    // Peak search over full-window gamma outputs
    // ------------------------------------------------------------------------
    assign gamma_mag = mag_sum(gamma_real, gamma_imag);
    assign cmp_en    = vld_p[TAGS-1] && (tag_k_out >= K_FULL) &&
                       (state == S_ACQ || state == S_DRAIN);

    // Strictly greater: ties keep the earliest index. The index subtraction
    // is done modulo 2^IDX_W, which is exact because it is below SEARCH.
    always_comb begin
        best_mag_nxt = best_mag;
        best_idx_nxt = best_idx;
        if (cmp_en && (gamma_mag > best_mag)) begin
            best_mag_nxt = gamma_mag;
            best_idx_nxt = tag_k_out[IDX_W-1:0] - IDX_OFF;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || state == S_CLR) begin
            best_mag <= '0;
            best_idx <= '0;
        end else begin
            best_mag <= best_mag_nxt;
            best_idx <= best_idx_nxt;
        end
    end

    // The final compare and the result publish share the DRAIN->DONE edge,
    // so the published value is taken from the next-best path.
    always_ff @(posedge clk) begin
        if (rst) begin
            peak_idx <= '0;
            peak_mag <= '0;
        end else if (state == S_DRAIN && state_nxt == S_DONE) begin
            peak_idx <= best_idx_nxt;
            peak_mag <= best_mag_nxt;
        end
    end

    // Stream break during ACQ: strobe in the first IDLE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_err <= 1'b0;
        end else begin
            sync_err <= (state == S_ACQ) && !in_valid;
        end
    end

endmodule

// File: tb/tb_gamma_sync_ctrl.sv
// -----------------------------------------------------------------------------
// tb_gamma_sync_ctrl
//
// Bench for gamma_sync_ctrl. The datapath is stubbed: the bench drives gamma_*
// itself from a per-search-index table, timed from the start pulse. Expected
// datapath inputs, strobes and the peak are derived from the sample arrays and
// the gamma table with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_gamma_sync_ctrl;

    localparam int R_W     = 8;
    localparam int GAMMA_W = 15;
    localparam int N       = 64;
    localparam int L       = 16;
    localparam int DP_LAT  = 3;
    localparam int SEARCH  = 80;
    localparam int IDX_W   = 7;

    localparam int FULL    = N + L - 1;          // 79
    localparam int TOTAL   = FULL + SEARCH;      // 159 samples per acquisition
    localparam int PEAK_C  = TOTAL + DP_LAT + 3; // 165: peak_valid cycle after start
    localparam int RUN_LEN = 170;

    logic                      clk;
    logic                      rst;
    logic                      start;
    logic                      in_valid;
    logic                      in_ready;
    logic signed [R_W-1:0]     in_real;
    logic signed [R_W-1:0]     in_imag;
    logic                      dp_rst;
    logic signed [R_W-1:0]     dp_rk_real;
    logic signed [R_W-1:0]     dp_rk_imag;
    logic signed [R_W-1:0]     dp_rkN_real;
    logic signed [R_W-1:0]     dp_rkN_imag;
    logic signed [GAMMA_W-1:0] gamma_real;
    logic signed [GAMMA_W-1:0] gamma_imag;
    logic                      busy;
    logic                      peak_valid;
    logic [IDX_W-1:0]          peak_idx;
    logic [GAMMA_W:0]          peak_mag;
    logic                      sync_err;

    gamma_sync_ctrl #(
        .R_W(R_W), .GAMMA_W(GAMMA_W), .N(N), .L(L),
        .DP_LAT(DP_LAT), .SEARCH(SEARCH), .IDX_W(IDX_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_real(in_real), .in_imag(in_imag),
        .dp_rst(dp_rst),
        .dp_rk_real(dp_rk_real), .dp_rk_imag(dp_rk_imag),
        .dp_rkN_real(dp_rkN_real), .dp_rkN_imag(dp_rkN_imag),
        .gamma_real(gamma_real), .gamma_imag(gamma_imag),
        .busy(busy), .peak_valid(peak_valid),
        .peak_idx(peak_idx), .peak_mag(peak_mag),
        .sync_err(sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic signed [R_W-1:0] s_re [TOTAL];
    logic signed [R_W-1:0] s_im [TOTAL];
    int g_re [SEARCH];
    int g_im [SEARCH];
    int cur_idx = 0;
    int cur_mag = 0;

    task automatic check(input string tag, input longint obs, input longint exp_v);
        checks++;
        if (obs != exp_v) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // lag=1: in_real = k mod 256, in_imag = ~k; otherwise random samples.
    task automatic fill_samples(input bit lag);
        for (int i = 0; i < TOTAL; i++) begin
            if (lag) begin
                s_re[i] = R_W'(i);
                s_im[i] = ~R_W'(i);
            end else begin
                s_re[i] = R_W'($urandom);
                s_im[i] = R_W'($urandom);
            end
        end
    endtask

    // Random gamma with |Re|+|Im| <= bound (exactly bound when exact=1).
    task automatic fill_table(input int bound, input bit exact);
        int a;
        int b;
        for (int i = 0; i < SEARCH; i++) begin
            a = int'($urandom_range(bound));
            b = exact ? (bound - a) : int'($urandom_range(bound - a));
            g_re[i] = $urandom_range(1) ? -a : a;
            g_im[i] = $urandom_range(1) ? -b : b;
        end
    endtask

    // One acquisition, cycle by cycle from the start pulse. abort_k >= 0 drops
    // in_valid at that sample; rst_cyc >= 0 pulses rst in that cycle; start_cyc
    // >= 0 pulses a spurious start in that cycle.
    task automatic run_acq(input string name, input int abort_k,
                           input int rst_cyc, input int start_cyc);
        int  exp_idx;
        int  exp_mag;
        int  m;
        int  idle_from;
        int  kmax;
        bit  normal;

        exp_idx = 0;
        exp_mag = 0;
        for (int i = 0; i < SEARCH; i++) begin
            m = iabs(g_re[i]) + iabs(g_im[i]);
            if (m > exp_mag) begin
                exp_mag = m;
                exp_idx = i;
            end
        end

        normal    = (abort_k < 0) && (rst_cyc < 0);
        idle_from = (abort_k >= 0) ? abort_k + 3 :
                    (rst_cyc >= 0) ? rst_cyc + 1 : PEAK_C + 1;
        kmax      = (abort_k >= 0) ? abort_k - 1 : TOTAL - 1;

        @(negedge clk);
        start    = 1'b1;
        in_valid = 1'b0;

        for (int n = 1; n <= RUN_LEN; n++) begin
            int k;
            int ks;
            int kg;
            int e_idx;
            int e_mag;
            longint e_rk_re, e_rk_im, e_rkn_re, e_rkn_im;

            @(negedge clk);

            check({name, " busy"},       busy,       n < idle_from);
            check({name, " in_ready"},   in_ready,   (n >= 2) && (n <= TOTAL + 1) && (n < idle_from));
            check({name, " dp_rst"},     dp_rst,     n == 1);
            check({name, " sync_err"},   sync_err,   (abort_k >= 0) && (n == abort_k + 3));
            check({name, " peak_valid"}, peak_valid, normal && (n == PEAK_C));

            k = n - 3;
            e_rk_re = 0; e_rk_im = 0; e_rkn_re = 0; e_rkn_im = 0;
            if (k >= 0 && k <= kmax) begin
                e_rk_re = s_re[k];
                e_rk_im = s_im[k];
                if (k >= N) begin
                    e_rkn_re = s_re[k-N];
                    e_rkn_im = s_im[k-N];
                end
            end
            check({name, " dp_rk_real"},  dp_rk_real,  e_rk_re);
            check({name, " dp_rk_imag"},  dp_rk_imag,  e_rk_im);
            check({name, " dp_rkN_real"}, dp_rkN_real, e_rkn_re);
            check({name, " dp_rkN_imag"}, dp_rkN_imag, e_rkn_im);

            e_idx = cur_idx;
            e_mag = cur_mag;
            if (normal && n >= PEAK_C) begin
                e_idx = exp_idx;
                e_mag = exp_mag;
            end else if (rst_cyc >= 0 && n >= idle_from) begin
                e_idx = 0;
                e_mag = 0;
            end
            check({name, " peak_idx"}, peak_idx, e_idx);
            check({name, " peak_mag"}, peak_mag, e_mag);

            // Drive inputs for this cycle.
            start = (n == start_cyc);
            rst   = (n == rst_cyc);
            ks    = n - 2;
            if (ks >= 0 && ks < TOTAL && !(abort_k >= 0 && ks >= abort_k)) begin
                in_valid = 1'b1;
                in_real  = s_re[ks];
                in_imag  = s_im[ks];
            end else begin
                in_valid = 1'b0;
                in_real  = R_W'($urandom);
                in_imag  = R_W'($urandom);
            end
            kg = n - 6;
            if (kg >= FULL && kg < TOTAL) begin
                gamma_real = GAMMA_W'(g_re[kg-FULL]);
                gamma_imag = GAMMA_W'(g_im[kg-FULL]);
            end else begin
                // Outside the search window the controller must ignore gamma.
                gamma_real = GAMMA_W'($urandom);
                gamma_imag = GAMMA_W'($urandom);
            end
        end

        if (normal) begin
            cur_idx = exp_idx;
            cur_mag = exp_mag;
        end else if (rst_cyc >= 0) begin
            cur_idx = 0;
            cur_mag = 0;
        end
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        in_valid   = 1'b0;
        in_real    = '0;
        in_imag    = '0;
        gamma_real = '0;
        gamma_imag = '0;

        // Reset held two cycles with random inputs; rst wins over start.
        repeat (2) begin
            @(negedge clk);
            start      = 1'($urandom);
            in_valid   = 1'($urandom);
            in_real    = R_W'($urandom);
            in_imag    = R_W'($urandom);
            gamma_real = GAMMA_W'($urandom);
            gamma_imag = GAMMA_W'($urandom);
        end
        @(negedge clk);
        check("rst in_ready",    in_ready,    0);
        check("rst dp_rst",      dp_rst,      0);
        check("rst dp_rk_real",  dp_rk_real,  0);
        check("rst dp_rk_imag",  dp_rk_imag,  0);
        check("rst dp_rkN_real", dp_rkN_real, 0);
        check("rst dp_rkN_imag", dp_rkN_imag, 0);
        check("rst busy",        busy,        0);
        check("rst peak_valid",  peak_valid,  0);
        check("rst peak_idx",    peak_idx,    0);
        check("rst peak_mag",    peak_mag,    0);
        check("rst sync_err",    sync_err,    0);
        rst      = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;

        // Lag alignment plus a single dominant peak.
        fill_samples(1'b1);
        fill_table(300, 1'b0);
        g_re[37] = -200; g_im[37] = 300;
        run_acq("peak37", -1, -1, -1);

        // Equal magnitudes: earliest index wins.
        fill_samples(1'b0);
        fill_table(150, 1'b0);
        g_re[10] = 200; g_im[10] = 0;
        g_re[50] = 0;   g_im[50] = -200;
        run_acq("tie", -1, -1, -1);

        // Negative components against a flat 399 background.
        fill_table(399, 1'b1);
        g_re[60] = -300; g_im[60] = -100;
        run_acq("sign", -1, -1, -1);

        // Most negative codes on both components.
        fill_table(16383, 1'b0);
        begin
            int xi;
            xi = int'($urandom_range(SEARCH - 1));
            g_re[xi] = -16384;
            g_im[xi] = -16384;
        end
        run_acq("extreme", -1, -1, -1);

        // Stream break at sample 100, then a fresh acquisition.
        fill_table(1000, 1'b0);
        run_acq("abort", 100, -1, -1);
        fill_samples(1'b0);
        fill_table(2000, 1'b0);
        run_acq("after_abort", -1, -1, -1);

        // Reset during DRAIN.
        fill_table(3000, 1'b0);
        run_acq("rst_drain", -1, TOTAL + 3, -1);

        // Spurious start while busy.
        fill_samples(1'b0);
        fill_table(5000, 1'b0);
        run_acq("start_busy", -1, -1, 50);

        // Fully random gamma.
        fill_table(16383, 1'b0);
        run_acq("random", -1, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gamma_sync_ctrl.md
# gamma_sync_ctrl

Sequencing controller for the sliding-window CP-correlation datapath that produces gamma. It accepts a continuous complex sample stream and feeds the datapath both r[k] and r[k-N], using an internal N-deep history buffer. It tags each sample through the datapath latency and searches a fixed window of full-window gamma outputs for the maximum |Re|+|Im|. When the search ends it reports the peak index and magnitude.

## Interface
- R_W, 8: sample component width (signed Q1.6)
- GAMMA_W, 15: gamma component width (signed Q6.8)
- N, 64: correlation lag; history buffer depth
- L, 16: datapath window length
- DP_LAT, 3: datapath latency, dp inputs to gamma output
- SEARCH, 80: number of gamma outputs compared
- IDX_W, 7: peak index width; must be ≥ clog2(SEARCH)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin one acquisition; ignored unless IDLE
- in_valid  in  1  sample valid
- in_ready  out  1  controller accepts sample
- in_real, in_imag  in  R_W each  incoming sample
- dp_rst  out  1  clears datapath state
- dp_rk_real, dp_rk_imag  out  R_W each  r[k] to datapath, registered
- dp_rkN_real, dp_rkN_imag  out  R_W each  r[k-N] to datapath, registered
- gamma_real, gamma_imag  in  GAMMA_W each  datapath output
- busy  out  1  high in every state except IDLE
- peak_valid  out  1  one-cycle result strobe
- peak_idx  out  IDX_W  search-relative index of the peak
- peak_mag  out  GAMMA_W+1  unsigned |Re|+|Im| at the peak
- sync_err  out  1  one-cycle strobe: stream broke during acquisition

## Operation
- States are IDLE, CLR, ACQ, DRAIN, DONE.
- IDLE
  - in_ready=0; dp inputs are driven 0.
  - start=1 → CLR.
- CLR (1 cycle)
  - dp_rst=1.
  - Sample counter k=0, history write pointer=0, best_mag=0, best_idx=0, tag pipe cleared.
  - → ACQ.
- ACQ
  - in_ready=1.
  - Each accepted sample (in_valid & in_ready):
    - Register in → dp_rk.
    - Register history[wptr] → dp_rkN (read-before-write), or 0 if k<N.
    - Write the sample to history[wptr]; wptr wraps N-1→0.
    - k++.
  - The datapath has no stall. An in_valid=0 cycle in ACQ aborts the acquisition: sync_err=1 next cycle, → IDLE, no peak_valid.
  - After the accept with k = N+L-2+SEARCH (total N+L-1+SEARCH samples), → DRAIN.
- Tag pipe
  - Depth DP_LAT+1. Carries {valid, k} alongside each accepted sample.
  - When the tag emerges with k ≥ N+L-1, the aligned gamma is a full window and is compared.
- Compare
  - mag = |gamma_real| + |gamma_imag|, unsigned, GAMMA_W+1 bits, no saturation. |−2^(GAMMA_W−1)| = 2^(GAMMA_W−1) exactly.
  - Replace best only if mag > best_mag (strictly greater), so a tie keeps the earliest index.
  - idx = k − (N+L−1).
- DRAIN
  - in_ready=0; dp inputs are driven 0.
  - Lasts until the last tag has been compared, then → DONE.
- DONE (1 cycle)
  - peak_valid=1; peak_idx and peak_mag are updated in the same cycle.
  - → IDLE.
- peak_idx and peak_mag hold their values until the next DONE or rst.
- rst at any time, including mid-ACQ, forces IDLE with all outputs 0. rst wins over a simultaneous start.
- start asserted while busy is ignored.

## Timing
- Reset values: in_ready, dp_rst, all dp_*, busy, peak_valid, peak_idx, peak_mag, sync_err are all 0.
- start sampled high at edge c → CLR during cycle c+1 (dp_rst=1) → ACQ from c+2 (in_ready=1).
- Sample accepted at edge t → dp_* valid during t+1 → its gamma is on gamma_* during t+1+DP_LAT.
- Last sample accepted at edge a:
  - DRAIN covers cycles a+1 … a+DP_LAT+1.
  - peak_valid is high during cycle a+DP_LAT+2 (a+5 with defaults).
  - busy falls the following cycle.
- in_valid=0 sampled in ACQ at edge t → sync_err high during t+1, busy=0 in t+1.
- Minimum start-to-peak_valid with a continuous stream is 2 + (N+L−1+SEARCH) + DP_LAT + 1 cycles = 165 with defaults.

## Test plan
- Reset: hold rst 2 cycles with random inputs → every output 0, in_ready 0; pulse start → dp_rst=1 exactly one cycle, in_ready=1 the cycle after.
- Lag alignment: stream in_real = k mod 256, in_imag = ~k → dp_rkN = 0 for k<64, dp_rkN_real = k−64 for k≥64, each dp_rk appears one cycle after its accept.
- Peak search with datapath stubbed (bench drives gamma per emerging tag):
  - magnitude 500 at search index 37, all others ≤ 300 → peak_idx=37, peak_mag=500, peak_valid exactly one cycle, 165 cycles after start.
- Tie and sign:
  - (200,0) at idx 10 and (0,−200) at idx 50 → peak_idx=10.
  - Then (−300,−100) at idx 60 against 399 elsewhere → peak_idx=60, peak_mag=400.
  - Extreme: (−16384,−16384) → peak_mag=32768.
- Stream break: deassert in_valid at sample 100 → sync_err one cycle, busy 0, no peak_valid; a new start then completes normally with fresh results.
- Mid-operation control:
  - rst during DRAIN → IDLE, peak_valid never asserted, peak_mag=0.
  - start pulsed during ACQ → no effect on k or the result.
